// File: rtl/if_fetch_queue.sv
// Instruction-fetch stage: owns the fetch PC, issues req/ack reads to instruction
// memory and buffers {pc, instruction} pairs in a small FIFO feeding decode.
module if_fetch_queue #(
  parameter int unsigned WORD      = 64,
  parameter int unsigned INSTR_LEN = 32,
  parameter int unsigned QDEPTH    = 2,
  parameter logic [WORD-1:0] RESET_PC = '0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 pc_src,
  input  logic [WORD-1:0]      branch_target,
  input  logic                 stall_id,
  output logic                 imem_req,
  output logic [WORD-1:0]      imem_addr,
  input  logic                 imem_ack,
  input  logic [INSTR_LEN-1:0] imem_rdata,
  output logic [INSTR_LEN-1:0] instruction,
  output logic [WORD-1:0]      cur_pc,
  output logic                 valid_out
);

  localparam int unsigned PTRW = $clog2(QDEPTH);
  localparam int unsigned CW   = PTRW + 1;
  localparam logic [CW-1:0] FULL = CW'(QDEPTH);
  localparam logic [INSTR_LEN-1:0] NOP = INSTR_LEN'(32'hD503201F);

  logic [WORD-1:0]      fetch_pc;
  logic [PTRW-1:0]      rd_ptr;
  logic [PTRW-1:0]      wr_ptr;
  logic [CW-1:0]        count;
  logic [WORD-1:0]      q_pc    [QDEPTH];
  logic [INSTR_LEN-1:0] q_instr [QDEPTH];

  logic push;
  logic pop;

  // Gating with reset makes imem_req drop asynchronously when reset asserts.
  assign imem_req  = reset && (count < FULL) && !pc_src;
  assign imem_addr = fetch_pc;
  assign valid_out = (count != '0);

  assign push = imem_req && imem_ack;
  assign pop  = valid_out && !stall_id && !pc_src;

  always_comb begin
    instruction = NOP;
    cur_pc      = '0;
    if (valid_out) begin
      instruction = q_instr[rd_ptr];
      cur_pc      = q_pc[rd_ptr];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc <= RESET_PC;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else if (pc_src) begin
      fetch_pc <= branch_target;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      if (push) begin
        fetch_pc <= fetch_pc + WORD'(4);
        wr_ptr   <= wr_ptr + PTRW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTRW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; entries are only visible while count covers them.
  always_ff @(posedge clk) begin
    if (push) begin
      q_pc[wr_ptr]    <= fetch_pc;
      q_instr[wr_ptr] <= imem_rdata;
    end
  end

endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed bench for if_fetch_queue (QDEPTH=2) with hand-computed expectations.
module tb_if_fetch_queue;

  logic        clk;
  logic        reset;
  logic        pc_src;
  logic [63:0] branch_target;
  logic        stall_id;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instruction;
  logic [63:0] cur_pc;
  logic        valid_out;

  int errors = 0;
  int checks = 0;

  localparam logic [31:0] NOP = 32'hD503201F;

  if_fetch_queue #(
    .WORD(64),
    .INSTR_LEN(32),
    .QDEPTH(2),
    .RESET_PC(64'h0)
  ) dut (
    .clk(clk),
    .reset(reset),
    .pc_src(pc_src),
    .branch_target(branch_target),
    .stall_id(stall_id),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_ack(imem_ack),
    .imem_rdata(imem_rdata),
    .instruction(instruction),
    .cur_pc(cur_pc),
    .valid_out(valid_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; pc_src = 1'b0; branch_target = '0; stall_id = 1'b1;
    imem_ack = 1'b0; imem_rdata = '0;
    #3;
    chk("rst_valid", 64'(valid_out), 64'd0);
    chk("rst_instr", 64'(instruction), 64'(NOP));
    chk("rst_curpc", cur_pc, 64'h0);
    chk("rst_req", 64'(imem_req), 64'd0);
    chk("rst_addr", imem_addr, 64'h0);

    // Stream: ack every cycle, no stall
    step();
    reset = 1'b1; stall_id = 1'b0; imem_ack = 1'b1; imem_rdata = 32'h8B020020;
    #1;
    chk("s_req0", 64'(imem_req), 64'd1);
    chk("s_valid_pre", 64'(valid_out), 64'd0);
    step();
    chk("s_valid1", 64'(valid_out), 64'd1);
    chk("s_pc0", cur_pc, 64'h0);
    chk("s_ins0", 64'(instruction), 64'h8B020020);
    chk("s_addr4", imem_addr, 64'h4);
    imem_rdata = 32'h8B030041;
    step();
    chk("s_pc4", cur_pc, 64'h4);
    chk("s_ins1", 64'(instruction), 64'h8B030041);
    chk("s_addr8", imem_addr, 64'h8);
    imem_rdata = 32'h8B040062;
    step();
    chk("s_pc8", cur_pc, 64'h8);
    chk("s_ins2", 64'(instruction), 64'h8B040062);

    // Asynchronous reset between edges
    reset = 1'b0;
    #1;
    chk("ar_req", 64'(imem_req), 64'd0);
    chk("ar_valid", 64'(valid_out), 64'd0);
    chk("ar_instr", 64'(instruction), 64'(NOP));
    reset = 1'b1;
    #1;
    chk("ar_addr", imem_addr, 64'h0);

    // Back-pressure
    stall_id = 1'b1; imem_ack = 1'b1; imem_rdata = 32'hA0000000;
    step();
    imem_rdata = 32'hA0000001;
    step();
    chk("bp_req", 64'(imem_req), 64'd0);
    chk("bp_addr", imem_addr, 64'h8);
    chk("bp_pc0", cur_pc, 64'h0);
    step();
    chk("bp_hold_pc", cur_pc, 64'h0);
    chk("bp_hold_addr", imem_addr, 64'h8);
    stall_id = 1'b0; imem_ack = 1'b0;
    step();
    chk("bp_pop_pc", cur_pc, 64'h4);
    chk("bp_pop_ins", 64'(instruction), 64'hA0000001);
    chk("bp_rereq", 64'(imem_req), 64'd1);

    // Variable latency: ack three cycles after request
    stall_id = 1'b1;
    step(); step(); step();
    chk("vl_addr_wait", imem_addr, 64'h8);
    chk("vl_head_wait", cur_pc, 64'h4);
    imem_ack = 1'b1; imem_rdata = 32'hA0000002;
    step();
    imem_ack = 1'b0;
    chk("vl_addr_adv", imem_addr, 64'hC);
    chk("vl_full_req", 64'(imem_req), 64'd0);
    stall_id = 1'b0;
    step();
    chk("vl_pc8", cur_pc, 64'h8);
    chk("vl_ins", 64'(instruction), 64'hA0000002);
    step();
    chk("vl_one_push", 64'(valid_out), 64'd0);
    chk("vl_addr_c", imem_addr, 64'hC);

    // Redirect with a full FIFO and concurrent ack
    stall_id = 1'b1; imem_ack = 1'b1; imem_rdata = 32'hB0000000;
    step();
    imem_rdata = 32'hB0000001;
    step();
    chk("rd_full_pc", cur_pc, 64'hC);
    pc_src = 1'b1; branch_target = 64'h40; imem_rdata = 32'hDEADBEEF;
    #1;
    chk("rd_req_low", 64'(imem_req), 64'd0);
    step();
    chk("rd_flush", 64'(valid_out), 64'd0);
    chk("rd_addr", imem_addr, 64'h40);
    pc_src = 1'b0;
    #1;
    chk("rd_req_next", 64'(imem_req), 64'd1);
    imem_rdata = 32'hC0000000; stall_id = 1'b0;
    step();
    chk("rd_first_pc", cur_pc, 64'h40);
    chk("rd_first_ins", 64'(instruction), 64'hC0000000);

    // Redirect during stall
    stall_id = 1'b1; imem_ack = 1'b0; pc_src = 1'b1; branch_target = 64'h100;
    step();
    pc_src = 1'b0;
    chk("rs_valid", 64'(valid_out), 64'd0);
    chk("rs_instr", 64'(instruction), 64'(NOP));
    chk("rs_curpc", cur_pc, 64'h0);
    chk("rs_addr", imem_addr, 64'h100);

    // PC wrap at the top of the address space
    pc_src = 1'b1; branch_target = 64'hFFFF_FFFF_FFFF_FFFC;
    step();
    pc_src = 1'b0; stall_id = 1'b0; imem_ack = 1'b1; imem_rdata = 32'hE0000000;
    step();
    imem_ack = 1'b0;
    chk("wr_pc", cur_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("wr_addr", imem_addr, 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/if_fetch_queue.md
Name: if_fetch_queue

Overview:
- Instruction-fetch stage that directly feeds the decode stage of the five-stage LEGv8 pipeline.
- Owns the fetch PC and talks to instruction memory over a req/ack handshake, so memory latency may vary.
- Buffers fetched instructions with their PCs in a small FIFO, so decode stalls do not drop fetches.
- Applies branch redirects from the memory stage: loads the new PC and flushes all queued wrong-path instructions.

Parameters:
- WORD, 64, PC and branch-target width (`WORD).
- INSTR_LEN, 32, instruction width (`INSTR_LEN).
- QDEPTH, 2, FIFO entries; legal values 2 or 4.
- RESET_PC, 0, fetch PC value after reset.

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- pc_src  in  1  redirect request from the memory stage (taken branch).
- branch_target  in  WORD  redirect PC, valid when pc_src=1.
- stall_id  in  1  decode cannot accept an instruction this cycle.
- imem_req  out  1  instruction-memory read request.
- imem_addr  out  WORD  read address, equal to fetch_pc.
- imem_ack  in  1  read data valid this cycle; counts only while imem_req=1.
- imem_rdata  in  INSTR_LEN  instruction word returned by memory.
- instruction  out  INSTR_LEN  FIFO head instruction to decode.
- cur_pc  out  WORD  PC of the FIFO head instruction.
- valid_out  out  1  FIFO head is valid.

Behaviour:
- Reset (reset=0, asynchronous):
  - fetch_pc=RESET_PC; FIFO empty; count=0; rd/wr pointers=0.
  - valid_out=0; instruction=32'hD503201F (NOP); cur_pc=0; imem_req=0.
- Request generation (combinational):
  - imem_req = reset && (count<QDEPTH) && !pc_src.
  - imem_addr = fetch_pc at all times.
- Accept:
  - An accept occurs on an edge where imem_req && imem_ack.
  - On accept, push {fetch_pc, imem_rdata} at the write pointer and set fetch_pc += 4 (mod 2^WORD; wraps from all-ones-minus-3 to 0).
  - Back-to-back accepts on consecutive cycles are legal, giving one instruction per cycle.
  - imem_ack while imem_req=0 is ignored.
- Pop:
  - A pop occurs on an edge where valid_out && !stall_id; it advances the read pointer.
- Simultaneous push and pop: count is unchanged, and this is legal even at count=QDEPTH-1.
- Full FIFO: count=QDEPTH forces imem_req=0; fetch_pc holds.
- Empty FIFO:
  - valid_out=0, instruction=NOP, cur_pc=0.
  - stall_id has no effect.
- Outputs:
  - instruction/cur_pc/valid_out are driven from registered FIFO state only; no combinational path from imem_rdata.
  - Fill latency: accept at edge N gives valid_out=1 after edge N.
- Redirect (pc_src=1 at an edge):
  - fetch_pc <= branch_target; FIFO cleared (count=0, pointers=0); no push; no pop.
  - imem_req is forced low in the pc_src cycle, so a concurrent imem_ack is discarded.
  - Instruction memory must treat imem_req falling without ack as an abandoned request.
  - The first target fetch is requested the cycle after the redirect edge.
- Priority: reset > pc_src > push/pop; pc_src overrides stall_id.
- Reset mid-request: the in-flight request is abandoned and imem_req drops immediately (asynchronous).
- Pointers are log2(QDEPTH) bits and wrap naturally.
- count is log2(QDEPTH)+1 bits.

Test Plan:
- Reset then stream: imem_ack=1 every cycle, rdata=8B020020,8B030041,…, stall_id=0 -> valid_out rises one cycle after the first accept; cur_pc sequence 0,4,8,…; instruction order matches.
- Back-pressure with QDEPTH=2: stall_id=1 after the first accept -> two entries held (pc 0,4), imem_req=0, fetch_pc=8; stall_id=0 -> pc 0 popped and imem_req re-asserts the same cycle.
- Variable latency: ack arrives 3 cycles after req -> imem_addr stable through the wait; exactly one push; fetch_pc advances only at the accept.
- Redirect with a full FIFO: pc_src=1, branch_target=0x40, imem_ack=1 in the same cycle -> FIFO empty next cycle; acked data discarded; next imem_addr=0x40; first valid cur_pc=0x40.
- Redirect during stall: stall_id=1, pc_src=1 -> flush still occurs; valid_out=0 next cycle.
- Asynchronous reset mid-stream: reset=0 between edges -> imem_req and valid_out drop immediately; after release, fetch restarts at RESET_PC.
